// File: rtl/panel_io_ctrl.sv
// panel_io_ctrl -- front-panel input controller for the pipelined MIPS board top.
//
// Synchronises and debounces the general switch/button inputs and produces
// one-cycle rising-edge pulses from them. It also stretches the system reset
// from the reset button and the clock-generator lock, and decodes a rotary
// encoder into per-channel display address registers.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   locked       clock generator lock (0 forces rst_out)
//   btn_reset_i  raw reset button
//   sig_i        raw general inputs [N_IN]
//   rot_a/rot_b  raw rotary encoder phases
//   sel          active address channel
//   rst_out      stretched system reset
//   sig_o        debounced inputs [N_IN]
//   rise_o       one-cycle rising-edge pulses of sig_o [N_IN]
//   addr_o       address register of the selected channel [ADDR_W]
//
// Build option: define DISP_ADDR_SAT_EN for saturating address registers;
// without it the address arithmetic wraps modulo 2^ADDR_W.

// One synchroniser + debouncer lane.
module panel_io_db #(
    parameter int   LIMIT = 10000,
    parameter int   CNT_W = 16,
    parameter logic INIT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);
    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // The count reaching LIMIT mismatched cycles is detected one step early
    // so the flip and the counter clear happen on the LIMIT-th mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            db   <= INIT;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(LIMIT - 1)) begin
                db  <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module panel_io_ctrl #(
    parameter int              N_IN           = 8,
    parameter int              JITTER_MAX     = 10000,
    parameter int              ROT_JITTER_MAX = 2000,
    parameter int              CNT_W          = 16,
    parameter logic [N_IN-1:0] INIT_MASK      = '0,
    parameter int              RST_STRETCH    = 16,
    parameter int              CHANNELS       = 4,
    parameter int              ADDR_W         = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        locked,
    input  logic                        btn_reset_i,
    input  logic [N_IN-1:0]             sig_i,
    input  logic                        rot_a,
    input  logic                        rot_b,
    input  logic [$clog2(CHANNELS)-1:0] sel,
    output logic                        rst_out,
    output logic [N_IN-1:0]             sig_o,
    output logic [N_IN-1:0]             rise_o,
    output logic [ADDR_W-1:0]           addr_o
);
    logic [N_IN-1:0]                 sig_o_d;
    logic                            btn_db;
    logic                            rot_a_db, rot_b_db, rot_a_d, rot_b_d;
    logic [RST_STRETCH-1:0]          shreg;
    logic [CHANNELS-1:0][ADDR_W-1:0] addr;
    logic                            a_rise, b_rise, inc, dec;
    logic [ADDR_W-1:0]               cur, nxt;

    generate
        for (genvar i = 0; i < N_IN; i++) begin : g_in
            panel_io_db #(.LIMIT(JITTER_MAX), .CNT_W(CNT_W), .INIT(INIT_MASK[i])) u_db (
                .clk(clk), .rst(rst), .raw(sig_i[i]), .db(sig_o[i])
            );
        end
    endgenerate

    // Button debounces to 1 so the stretcher stays asserted out of reset.
    panel_io_db #(.LIMIT(JITTER_MAX), .CNT_W(CNT_W), .INIT(1'b1)) u_btn (
        .clk(clk), .rst(rst), .raw(btn_reset_i), .db(btn_db)
    );
    panel_io_db #(.LIMIT(ROT_JITTER_MAX), .CNT_W(CNT_W), .INIT(1'b0)) u_rot_a (
        .clk(clk), .rst(rst), .raw(rot_a), .db(rot_a_db)
    );
    panel_io_db #(.LIMIT(ROT_JITTER_MAX), .CNT_W(CNT_W), .INIT(1'b0)) u_rot_b (
        .clk(clk), .rst(rst), .raw(rot_b), .db(rot_b_db)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_o_d <= INIT_MASK;
            rot_a_d <= 1'b0;
            rot_b_d <= 1'b0;
            shreg   <= '1;
            rst_out <= 1'b1;
        end else begin
            sig_o_d <= sig_o;
            rot_a_d <= rot_a_db;
            rot_b_d <= rot_b_db;
            shreg   <= {shreg[RST_STRETCH-2:0], btn_db | ~locked};
            rst_out <= |shreg;
        end
    end

    // sig_o_d resets to the same value as sig_o, so leaving reset never pulses.
    assign rise_o = sig_o & ~sig_o_d;

    always_comb begin
        a_rise = rot_a_db & ~rot_a_d;
        b_rise = rot_b_db & ~rot_b_d;
        dec    = a_rise & ~rot_b_db & ~b_rise;
        inc    = b_rise & ~rot_a_db & ~a_rise;
        cur    = addr[sel];
        nxt    = cur;
`ifdef DISP_ADDR_SAT_EN
        if (dec)      nxt = (cur == '0) ? cur : cur - 1'b1;
        else if (inc) nxt = (cur == '1) ? cur : cur + 1'b1;
`else
        if (dec)      nxt = cur - 1'b1;
        else if (inc) nxt = cur + 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || rst_out) begin
            addr <= '0;
        end else if (inc || dec) begin
            addr[sel] <= nxt;
        end
    end

    assign addr_o = addr[sel];
endmodule
